// File: rtl/regfile_haz.sv
// Register file with EX/MEM/WB bypass for two read ports and a load-use stall detector.
// Entry 0 is hardwired to zero; a saturating counter tracks cycles spent stalled.
module regfile_haz #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              rd1_en,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  input  logic              rd2_en,
  output logic [DATA_W-1:0] rdata2,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_waddr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              ex_rdy,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdy,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall_req,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    SRC_ZERO,
    SRC_EX,
    SRC_MEM,
    SRC_WB,
    SRC_ARR
  } src_e;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [ADDR_W-1:0] port_addr [2];
  logic              port_en   [2];

  assign port_addr[0] = raddr1;
  assign port_addr[1] = raddr2;
  assign port_en[0]   = rd1_en;
  assign port_en[1]   = rd2_en;

  // Youngest producer wins: EX, then MEM, then the commit being written this cycle.
  for (genvar p = 0; p < 2; p++) begin : g_port
    src_e              src;
    logic [DATA_W-1:0] data;
    logic              hazard;

    always_comb begin
      src = SRC_ARR;
      if (port_addr[p] == '0) begin
        src = SRC_ZERO;
      end else if (ex_we && (ex_waddr == port_addr[p])) begin
        src = SRC_EX;
      end else if (mem_we && (mem_waddr == port_addr[p])) begin
        src = SRC_MEM;
      end else if (we && (waddr == port_addr[p])) begin
        src = SRC_WB;
      end
    end

    always_comb begin
      data = '0;
      case (src)
        SRC_ZERO: data = '0;
        SRC_EX:   data = ex_wdata;
        SRC_MEM:  data = mem_wdata;
        SRC_WB:   data = wdata;
        default:  data = regs_q[port_addr[p]];
      endcase
    end

    assign hazard = port_en[p] &&
                    (((src == SRC_EX) && !ex_rdy) || ((src == SRC_MEM) && !mem_rdy));
  end

  assign rdata1    = g_port[0].data;
  assign rdata2    = g_port[1].data;
  assign stall_req = g_port[0].hazard || g_port[1].hazard;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_req && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_haz.sv
// Directed bench for regfile_haz: bypass priority, stall detection, counter saturation
// (on a narrow-counter twin instance sharing the same inputs) and reset behaviour.
module tb_regfile_haz;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  raddr1, raddr2, ex_waddr, mem_waddr, waddr;
  logic        rd1_en, rd2_en, ex_we, ex_rdy, mem_we, mem_rdy, we;
  logic [31:0] ex_wdata, mem_wdata, wdata;
  logic [31:0] rdata1, rdata2, rdata1_s, rdata2_s;
  logic        stall_req, stall_req_s;
  logic [31:0] stall_cnt;
  logic [3:0]  stall_cnt_s;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  regfile_haz #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .raddr1(raddr1), .rd1_en(rd1_en), .rdata1(rdata1),
    .raddr2(raddr2), .rd2_en(rd2_en), .rdata2(rdata2),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_rdy(ex_rdy),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_rdy(mem_rdy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .stall_req(stall_req), .stall_cnt(stall_cnt)
  );

  regfile_haz #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .raddr1(raddr1), .rd1_en(rd1_en), .rdata1(rdata1_s),
    .raddr2(raddr2), .rd2_en(rd2_en), .rdata2(rdata2_s),
    .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_rdy(ex_rdy),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_rdy(mem_rdy),
    .we(we), .waddr(waddr), .wdata(wdata),
    .stall_req(stall_req_s), .stall_cnt(stall_cnt_s)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge so inputs change away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    raddr1 = '0; raddr2 = '0; rd1_en = 0; rd2_en = 0;
    ex_we = 0; ex_waddr = '0; ex_wdata = '0; ex_rdy = 1;
    mem_we = 0; mem_waddr = '0; mem_wdata = '0; mem_rdy = 1;
    we = 0; waddr = '0; wdata = '0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Cleared state after reset
    check_val("rst_stall_cnt", stall_cnt, 0);
    check_val("rst_stall_cnt_s", stall_cnt_s, 0);
    check_val("rst_stall_req", stall_req, 0);
    for (int r = 1; r < 32; r++) begin
      raddr1 = r[4:0];
      raddr2 = r[4:0];
      #1;
      check_val($sformatf("rst_rd1_r%0d", r), rdata1, 0);
      check_val($sformatf("rst_rd2_r%0d", r), rdata2, 0);
    end

    // Commit bypass, then array holds the value
    we = 1; waddr = 5; wdata = 32'hDEADBEEF; raddr1 = 5; raddr2 = 5;
    #1;
    check_val("wb_bypass", rdata1, 32'hDEADBEEF);
    check_val("wb_bypass_p2_same", rdata2, 32'hDEADBEEF);
    tick();
    we = 0;
    #1;
    check_val("wb_array", rdata1, 32'hDEADBEEF);

    // Priority EX > MEM > array
    we = 1; waddr = 7; wdata = 32'h11;
    tick();
    we = 0;
    mem_we = 1; mem_waddr = 7; mem_wdata = 32'h22; mem_rdy = 1;
    ex_we = 1; ex_waddr = 7; ex_wdata = 32'h33; ex_rdy = 1;
    raddr2 = 7; rd2_en = 1; raddr1 = 7; rd1_en = 1;
    #1;
    check_val("prio_ex", rdata2, 32'h33);
    check_val("prio_ex_p1_same", rdata1, 32'h33);
    check_val("prio_ex_nostall", stall_req, 0);
    ex_we = 0;
    #1;
    check_val("prio_mem", rdata2, 32'h22);
    mem_we = 0;
    #1;
    check_val("prio_arr", rdata2, 32'h11);
    // Younger ready EX shields an older not-ready MEM
    mem_we = 1; mem_rdy = 0; ex_we = 1; ex_rdy = 1; ex_wdata = 32'h44;
    #1;
    check_val("ex_shields_mem_data", rdata2, 32'h44);
    check_val("ex_shields_mem_stall", stall_req, 0);
    ex_we = 0;
    rd1_en = 0;
    #1;
    check_val("mem_notrdy_stall", stall_req, 1);
    idle_inputs();

    // EX load-use hazard: counts one cycle only when the operand is used
    ex_we = 1; ex_waddr = 3; ex_rdy = 0; raddr1 = 3; rd1_en = 1;
    #1;
    check_val("ex_hazard_stall", stall_req, 1);
    tick();
    check_val("ex_hazard_cnt", stall_cnt, 1);
    check_val("ex_hazard_cnt_s", stall_cnt_s, 1);
    rd1_en = 0;
    #1;
    check_val("unused_no_stall", stall_req, 0);
    tick();
    check_val("unused_cnt_held", stall_cnt, 1);

    // Address 0 never matches or stalls, and r0 stays zero
    idle_inputs();
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF;
    ex_we = 1; ex_waddr = 0; ex_rdy = 0; raddr1 = 0; rd1_en = 1;
    #1;
    check_val("r0_read", rdata1, 0);
    check_val("r0_no_stall", stall_req, 0);
    tick();
    idle_inputs();
    #1;
    check_val("r0_after_write", rdata1, 0);
    check_val("r0_cnt_held", stall_cnt, 1);

    // Long stall: 32-bit counter goes 1 -> 21, 4-bit counter saturates at 15
    ex_we = 1; ex_waddr = 3; ex_rdy = 0; raddr1 = 3; rd1_en = 1;
    repeat (20) tick();
    check_val("sat_cnt_wide", stall_cnt, 21);
    check_val("sat_cnt_narrow", stall_cnt_s, 15);

    // Reset mid-stall with a commit write pending: write dropped, counters and array cleared
    rst = 1; we = 1; waddr = 5; wdata = 32'h1234; raddr2 = 5;
    #1;
    check_val("rst_comb_stall", stall_req, 1);
    check_val("rst_comb_bypass", rdata2, 32'h1234);
    tick();
    rst = 0; we = 0;
    #1;
    check_val("rst_mid_cnt", stall_cnt, 0);
    check_val("rst_mid_cnt_s", stall_cnt_s, 0);
    check_val("rst_drops_write", rdata2, 0);
    raddr2 = 7;
    #1;
    check_val("rst_clears_r7", rdata2, 0);
    tick();
    check_val("resume_cnt", stall_cnt, 1);
    check_val("resume_cnt_s", stall_cnt_s, 1);
    idle_inputs();
    tick();
    check_val("idle_cnt", stall_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/regfile_haz.md
REGFILE_HAZ -- requirements
Module: regfile_haz

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register/data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; depth = 2^ADDR_W entries.
REQ-003 SHALL have parameter CNT_W, default 32, width of the stall performance counter.
REQ-004 SHALL have ports (name  direction  width  meaning):
  clk  in  1  sole clock, all state updates on rising edge
  rst  in  1  reset, synchronous, active-high
  raddr1  in  ADDR_W  read port 1 address
  rd1_en  in  1  read port 1 operand used by current ID instruction
  rdata1  out  DATA_W  read port 1 data
  raddr2  in  ADDR_W  read port 2 address
  rd2_en  in  1  read port 2 operand used
  rdata2  out  DATA_W  read port 2 data
  ex_we  in  1  EX-stage instruction will write a register
  ex_waddr  in  ADDR_W  EX destination
  ex_wdata  in  DATA_W  EX result
  ex_rdy  in  1  EX result final (0 for loads)
  mem_we  in  1  MEM-stage instruction will write
  mem_waddr  in  ADDR_W  MEM destination
  mem_wdata  in  DATA_W  MEM result
  mem_rdy  in  1  MEM result final (0 while load data outstanding)
  we  in  1  WB commit write enable
  waddr  in  ADDR_W  WB commit address
  wdata  in  DATA_W  WB commit data
  stall_req  out  1  ID must hold: an operand is not yet available
  stall_cnt  out  CNT_W  count of cycles stall_req was 1

Function
REQ-005 Write: at rising clk with rst=0, we=1 and waddr!=0 SHALL store wdata into entry waddr; waddr=0 SHALL never be written.
REQ-006 Entry 0 SHALL read as 0 always; a source with waddr 0 SHALL never match a read.
REQ-007 Read per port, combinational, priority order: addr=0 -> 0; match EX (ex_we & ex_waddr==raddr) -> ex_wdata; else match MEM -> mem_wdata; else match commit (we & waddr==raddr) -> wdata; else array entry.
REQ-008 Only the highest-priority matching source SHALL be used; an older stage SHALL never override a younger match.
REQ-009 Port hazard = rdN_en & selected source is EX with ex_rdy=0, or selected source is MEM with mem_rdy=0.
REQ-010 stall_req SHALL be OR of port-1 and port-2 hazards, combinational, zero cycles latency.
REQ-011 When a port's selected source is not ready, rdataN value is don't-care; consumers SHALL ignore it while stall_req=1.
REQ-012 A matching source with rdN_en=0 SHALL NOT raise stall_req.
REQ-013 Commit write and bypass of same address same cycle: read SHALL return wdata (bypass); array holds wdata from next cycle.
REQ-014 stall_cnt SHALL increment by 1 at each rising clk where stall_req=1 and rst=0, saturating at 2^CNT_W-1 (no wrap).
REQ-015 Both read ports SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-016 DATA_W/ADDR_W changes SHALL require no logic change; all compares full ADDR_W wide.

Reset
REQ-017 With rst=1 at rising clk, all 2^ADDR_W entries SHALL become 0 and stall_cnt SHALL become 0.
REQ-018 rst=1 SHALL take precedence over a simultaneous commit write (write discarded).
REQ-019 Outputs rdataN, stall_req SHALL remain combinational during reset (from bypass inputs and cleared array after the edge).
REQ-020 Reset mid-stall SHALL clear stall_cnt on that edge; counting resumes the first cycle after rst deasserts.

Verification
REQ-021 Reset, then read r1..r31 with all we=0 -> rdata=0, stall_cnt=0.
REQ-022 Commit we=1 waddr=5 wdata=0xDEADBEEF, same cycle raddr1=5 -> rdata1=0xDEADBEEF; next cycle with we=0 -> still 0xDEADBEEF.
REQ-023 Array r7=0x11; mem_we waddr=7 data=0x22 rdy=1; ex_we waddr=7 data=0x33 rdy=1; raddr2=7 -> rdata2=0x33; drop ex_we -> 0x22; drop mem_we -> 0x11.
REQ-024 ex_we waddr=3 ex_rdy=0, raddr1=3 rd1_en=1 for 1 cycle -> stall_req=1, stall_cnt 0->1; same with rd1_en=0 -> stall_req=0, count unchanged.
REQ-025 we=1 waddr=0 wdata=0xFFFFFFFF, ex_we waddr=0 ex_rdy=0, raddr1=0 rd1_en=1 -> rdata1=0, stall_req=0, r0 stays 0.
REQ-026 CNT_W=4, hold stall 20 cycles -> stall_cnt saturates at 15; assert rst -> 0 next edge.
